// File: rtl/croc_gpio_in_cond.sv
// croc_gpio_in_cond: pad input synchroniser, debouncer, edge pulses and sticky IRQ pending (optional glitch counters via CROC_GPIO_GLITCH_CNT_EN)
module croc_gpio_in_cond #(
  parameter int GpioCount  = 20,
  parameter int CntWidth   = 16,
  parameter int SyncStages = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [GpioCount-1:0]   pad_gpio_i,
  input  logic [CntWidth-1:0]    debounce_thr_i,
  input  logic [GpioCount-1:0]   rise_en_i,
  input  logic [GpioCount-1:0]   fall_en_i,
  input  logic [GpioCount-1:0]   irq_clr_i,
`ifdef CROC_GPIO_GLITCH_CNT_EN
  input  logic [GpioCount-1:0]   glitch_clr_i,
  output logic [GpioCount*8-1:0] glitch_cnt_o,
`endif
  output logic [GpioCount-1:0]   gpio_o,
  output logic [GpioCount-1:0]   rise_o,
  output logic [GpioCount-1:0]   fall_o,
  output logic [GpioCount-1:0]   irq_pending_o,
  output logic                   irq_o
);
  logic [GpioCount-1:0] sync_q [SyncStages];
  logic [CntWidth-1:0]  cnt_q  [GpioCount];
  logic [GpioCount-1:0] sync, stable_q, mis, flip;
  assign sync = sync_q[SyncStages-1];
  // per-pin mismatch and "threshold reached, accept new level" decisions
  always_comb begin
    mis  = sync ^ stable_q;
    flip = '0;
    for (int i = 0; i < GpioCount; i++) flip[i] = mis[i] && (cnt_q[i] >= debounce_thr_i);
  end
  // metastability chain bringing pad levels into the clk_i domain
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) for (int s = 0; s < SyncStages; s++) sync_q[s] <= '0;
    else begin
      sync_q[0] <= pad_gpio_i;
      for (int s = 1; s < SyncStages; s++) sync_q[s] <= sync_q[s-1];
    end
  // debounce counters, stable level and registered edge pulses
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      stable_q <= '0;
      rise_o   <= '0;
      fall_o   <= '0;
      for (int i = 0; i < GpioCount; i++) cnt_q[i] <= '0;
    end else begin
      stable_q <= stable_q ^ flip;
      rise_o   <= flip & sync;
      fall_o   <= flip & ~sync;
      for (int i = 0; i < GpioCount; i++) cnt_q[i] <= (mis[i] && !flip[i]) ? cnt_q[i] + 1'b1 : '0;
    end
  // sticky pending bits; a new edge beats a simultaneous clear
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) irq_pending_o <= '0;
    else irq_pending_o <= (rise_o & rise_en_i) | (fall_o & fall_en_i) | (irq_pending_o & ~irq_clr_i);
  assign gpio_o = stable_q;
  assign irq_o  = |irq_pending_o;
`ifdef CROC_GPIO_GLITCH_CNT_EN
  logic [7:0] glitch_q [GpioCount];
  // count rejected transitions (level fell back while a count was running), saturating
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) for (int i = 0; i < GpioCount; i++) glitch_q[i] <= '0;
    else for (int i = 0; i < GpioCount; i++)
      glitch_q[i] <= glitch_clr_i[i] ? 8'd0 :
                     (!mis[i] && cnt_q[i] != '0 && glitch_q[i] != 8'hff) ? glitch_q[i] + 8'd1 : glitch_q[i];
  always_comb begin
    glitch_cnt_o = '0;
    for (int i = 0; i < GpioCount; i++) glitch_cnt_o[i*8 +: 8] = glitch_q[i];
  end
`endif
endmodule

// File: tb/tb_croc_gpio_in_cond.sv
// tb_croc_gpio_in_cond: directed self-checking bench for croc_gpio_in_cond
module tb_croc_gpio_in_cond;
  localparam int N = 20;
  localparam int CW = 16;
  localparam int SS = 2;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  pad = '0;
  logic [CW-1:0] thr = '0;
  logic [N-1:0]  rise_en = '0, fall_en = '0, irq_clr = '0;
  logic [N-1:0]  gpio, rise, fall, pending;
  logic          irq;
  int checks = 0;
  int errors = 0;
`ifdef CROC_GPIO_GLITCH_CNT_EN
  logic [N-1:0]   glitch_clr = '0;
  logic [N*8-1:0] glitch_cnt;
`endif

  croc_gpio_in_cond #(.GpioCount(N), .CntWidth(CW), .SyncStages(SS)) dut (
    .clk_i(clk), .rst_i(rst), .pad_gpio_i(pad), .debounce_thr_i(thr),
    .rise_en_i(rise_en), .fall_en_i(fall_en), .irq_clr_i(irq_clr),
`ifdef CROC_GPIO_GLITCH_CNT_EN
    .glitch_clr_i(glitch_clr), .glitch_cnt_o(glitch_cnt),
`endif
    .gpio_o(gpio), .rise_o(rise), .fall_o(fall), .irq_pending_o(pending), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int pulses;
    logic [N-1:0] exp;
    rst = 1'b1; pad = '1; thr = 16'd3;
    repeat (3) step();
    checks++; if (gpio !== '0) begin errors++; $display("FAIL reset_gpio got %h want 0", gpio); end
    checks++; if (rise !== '0 || fall !== '0) begin errors++; $display("FAIL reset_edges got rise %h fall %h want 0", rise, fall); end
    checks++; if (pending !== '0 || irq !== 1'b0) begin errors++; $display("FAIL reset_irq got pend %h irq %b want 0", pending, irq); end
    rst = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp = (k >= SS + 4) ? '1 : '0;
      if (rise === '1) pulses++;
      checks++; if (gpio !== exp) begin errors++; $display("FAIL rst_high_gpio cyc %0d got %h want %h", k, gpio, exp); end
      exp = (k == SS + 4) ? '1 : '0;
      checks++; if (rise !== exp) begin errors++; $display("FAIL rst_high_rise cyc %0d got %h want %h", k, rise, exp); end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL rst_high_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_latency();
    pad = '0; thr = 16'd0;
    repeat (6) step();
    checks++; if (gpio !== '0) begin errors++; $display("FAIL settle_low got %h want 0", gpio); end
    pad[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++; if (gpio[0] !== (k >= SS + 1)) begin errors++; $display("FAIL lat0_gpio cyc %0d got %b want %b", k, gpio[0], k >= SS + 1); end
      checks++; if (rise[0] !== (k == SS + 1)) begin errors++; $display("FAIL lat0_rise cyc %0d got %b want %b", k, rise[0], k == SS + 1); end
    end
    thr = 16'd10; pad[0] = 1'b0;
    repeat (20) step();
    pad[0] = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      checks++; if (gpio[0] !== (k >= SS + 11)) begin errors++; $display("FAIL lat10_gpio cyc %0d got %b want %b", k, gpio[0], k >= SS + 11); end
      checks++; if (rise[0] !== (k == SS + 11)) begin errors++; $display("FAIL lat10_rise cyc %0d got %b want %b", k, rise[0], k == SS + 11); end
    end
  endtask

  task automatic test_glitch();
    thr = 16'd4;
    pad[5] = 1'b1;
    repeat (3) step();
    pad[5] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++; if (gpio[5] !== 1'b0 || rise[5] !== 1'b0) begin errors++; $display("FAIL glitch_reject cyc %0d got gpio %b rise %b want 0 0", k, gpio[5], rise[5]); end
    end
`ifdef CROC_GPIO_GLITCH_CNT_EN
    checks++; if (glitch_cnt[5*8 +: 8] !== 8'd1) begin errors++; $display("FAIL glitch_cnt got %0d want 1", glitch_cnt[5*8 +: 8]); end
    glitch_clr[5] = 1'b1;
    step();
    glitch_clr[5] = 1'b0;
    checks++; if (glitch_cnt[5*8 +: 8] !== 8'd0) begin errors++; $display("FAIL glitch_clr got %0d want 0", glitch_cnt[5*8 +: 8]); end
`endif
  endtask

  task automatic test_irq();
    thr = 16'd0; rise_en[3] = 1'b1; fall_en[3] = 1'b0;
    pad[3] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++; if (rise[3] !== (k == SS + 1)) begin errors++; $display("FAIL irq_rise cyc %0d got %b want %b", k, rise[3], k == SS + 1); end
      checks++; if (pending[3] !== (k >= SS + 2) || irq !== (k >= SS + 2)) begin errors++; $display("FAIL irq_set cyc %0d got pend %b irq %b want %b", k, pending[3], irq, k >= SS + 2); end
    end
    pad[3] = 1'b0;
    repeat (5) step();
    checks++; if (pending !== 20'h00008) begin errors++; $display("FAIL irq_fall_masked got %h want 00008", pending); end
    rise_en[3] = 1'b0;
    step();
    checks++; if (pending !== 20'h00008) begin errors++; $display("FAIL irq_en_change got %h want 00008", pending); end
    irq_clr[3] = 1'b1;
    step();
    irq_clr[3] = 1'b0;
    checks++; if (pending !== '0 || irq !== 1'b0) begin errors++; $display("FAIL irq_clear got pend %h irq %b want 0 0", pending, irq); end
  endtask

  task automatic test_collision();
    int n;
    thr = 16'd0; rise_en[7] = 1'b1;
    pad[7] = 1'b1;
    n = 0;
    do begin step(); n++; end while (rise[7] !== 1'b1 && n < 10);
    checks++; if (rise[7] !== 1'b1) begin errors++; $display("FAIL coll_timeout got rise %b want 1", rise[7]); end
    irq_clr[7] = 1'b1;
    step();
    irq_clr[7] = 1'b0;
    checks++; if (pending[7] !== 1'b1) begin errors++; $display("FAIL coll_set_wins got %b want 1", pending[7]); end
    step();
    checks++; if (pending[7] !== 1'b1) begin errors++; $display("FAIL coll_sticky got %b want 1", pending[7]); end
    irq_clr[7] = 1'b1;
    step();
    irq_clr[7] = 1'b0;
    checks++; if (pending[7] !== 1'b0) begin errors++; $display("FAIL coll_clear got %b want 0", pending[7]); end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] exp;
    thr = 16'd0; rise_en[3] = 1'b1;
    pad = '1;
    repeat (5) step();
    checks++; if (gpio !== '1 || irq !== 1'b1) begin errors++; $display("FAIL mid_pre got gpio %h irq %b want fffff 1", gpio, irq); end
    thr = 16'd100; pad = '0;
    repeat (52) step();
    checks++; if (gpio !== '1) begin errors++; $display("FAIL mid_counting got %h want fffff", gpio); end
    rst = 1'b1; pad = '1;
    #1;
    checks++; if (gpio !== '0 || pending !== '0 || irq !== 1'b0 || rise !== '0 || fall !== '0) begin
      errors++; $display("FAIL mid_async_rst got gpio %h pend %h irq %b rise %h fall %h want 0", gpio, pending, irq, rise, fall);
    end
    repeat (2) step();
    rst = 1'b0;
    for (int k = 1; k <= 105; k++) begin
      step();
      exp = (k >= SS + 101) ? '1 : '0;
      checks++; if (gpio !== exp) begin errors++; $display("FAIL mid_relatch cyc %0d got %h want %h", k, gpio, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_irq();
    test_collision();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
